alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes ALUOp/Funct3/Funct7/jals into an OP_W-bit operation code and registers it as the ID/EX stage output.
- Adds RV32M multiply/divide decode plus a fixed-latency multi-cycle sequencer. The sequencer stalls the pipeline while the iterative MUL/DIV unit runs.
- Sits between the main Controller and the ALU / MUL-DIV datapath.

Parameters:
- OP_W, 5, operation code width; minimum 5 when EN_M=1, otherwise minimum 4.
- EN_M, 1, 1 enables M-extension decode and sequencing; 0 decodes Funct7=0000001 as base ops.
- MD_LAT, 32, MUL/DIV busy cycles per operation; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash current and in-flight op (branch taken / trap).
- stall_in  in  1  external hazard hold; freezes registered outputs.
- valid_in  in  1  decode inputs carry a real instruction.
- rtype  in  1  instruction is R-type (qualifies M decode).
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- Funct3  in  3  instr[14:12].
- Funct7  in  7  instr[31:25].
- jals  in  1  with ALUOp=11: 1 JAL, 0 LUI.
- op_q  out  OP_W  registered operation code.
- valid_q  out  1  op_q is valid.
- md_start  out  1  one-cycle pulse launching the MUL/DIV unit.
- md_funct  out  3  registered Funct3 of the M op (MUL..REMU).
- md_last  out  1  final busy cycle of the M op; result is captured this cycle.
- md_abort  out  1  one-cycle pulse when an M op is flushed mid-run.
- stall_req  out  1  pipeline hold request while the M op is busy.

Behaviour:
Decode (combinational). Codes are zero-extended to OP_W.
- ALUOp=00 -> 1011 (ADD).
- ALUOp=11, jals=0 -> 0010 (LUI). jals=1 -> 1110 (JAL).
- ALUOp=01, by Funct3: 000 -> 1000 (BEQ); 001 -> 1001 (BNE); 100 -> 0110 (BLT); 101 -> 0111 (BGE).
- ALUOp=10, by Funct3/Funct7:
  - 000 with Funct7 != 0100000 -> 1011 (ADD); with Funct7 = 0100000 -> 1010 (SUB).
  - 001 -> 0100 (SLL).
  - 010 -> 1100 (SLT).
  - 100 with Funct7 = 0 -> 0011 (XOR).
  - 110 with Funct7 = 0 -> 0001 (OR).
  - 111 -> 0000 (AND).
  - 101 with Funct7[5]=0 -> 0101 (SRL); with Funct7[5]=1 -> 1101 (SRA).
- M op: EN_M=1, ALUOp=10, rtype=1 and Funct7=0000001 -> {1,0,Funct3}, i.e. 10000 plus Funct3. This takes priority over all ALUOp=10 entries above.
- Any other combination -> 0.

Registered stage:
- Reset (async, rst_n=0): op_q=0, valid_q=0, md_funct=0, md_start=0, md_last=0, md_abort=0, stall_req=0, FSM=IDLE, counter=0.
- Advance condition: stall_in=0 and stall_req=0. On advance, op_q <= decoded code and valid_q <= valid_in. Latency is 1 cycle.
- Otherwise op_q and valid_q hold.
- flush: next edge forces op_q=0 and valid_q=0. flush has priority over stall_in and stall_req.

FSM (IDLE, RUN):
- IDLE -> RUN when an M op is accepted: advance, valid_in=1, flush=0.
  - On that edge: md_funct <= Funct3, counter <= MD_LAT-1, md_start=1 for the following cycle.
  - Non-M ops stay in IDLE.
- RUN:
  - stall_req=1 except in the last cycle.
  - Counter decrements each cycle; stall_in does not pause it.
  - When counter=0: md_last=1 and stall_req=0, so the next instruction advances at this edge. Return to IDLE.
  - While in RUN, decode inputs are ignored and op_q/valid_q hold the M op.
- MD_LAT=1: the md_start cycle is also the md_last cycle, and stall_req is never asserted.
- Back-to-back M ops: an M op accepted on the md_last edge re-enters RUN directly, with md_start pulsing the next cycle.
- flush in RUN: next edge returns to IDLE, clears the counter, pulses md_abort for 1 cycle, and md_last is not asserted.
- flush on the md_last cycle: op completes (no abort); the registered op is still squashed.
- rst_n asserted mid-RUN: immediate return to reset values; no md_abort.

Test Plan:
- Reset: rst_n=0 mid-RUN with counter=17 -> all outputs 0 asynchronously, FSM IDLE; after release, ADD issues normally.
- Base decode: ALUOp=10, F3=000, F7=0100000, valid_in=1 -> op_q=01010, valid_q=1 next cycle; SRA (F3=101, F7=0100000) -> 01101; BNE (ALUOp=01, F3=001) -> 01001; JAL -> 01110.
- MUL sequence with MD_LAT=4: MULH (F3=001, F7=0000001, rtype=1) -> op_q=10001, md_start 1 cycle, stall_req high 3 cycles, md_last on the 4th, next ADD accepted on the md_last edge.
- EN_M=0 or rtype=0 with F7=0000001, F3=000 -> op_q=01011 (ADD), no md_start, stall_req stays 0.
- Flush: DIV with MD_LAT=32, flush at busy cycle 10 -> md_abort pulse, stall_req=0, valid_q=0, no md_last; stall_in held high during RUN does not extend the 32-cycle count.
- MD_LAT=1, two back-to-back REM ops -> md_start and md_last coincide each cycle, stall_req stays 0, op_q=10110 twice.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Decode-to-execute bundle between the Controller, the ALU control stage and the MUL/DIV unit.
// master drives the instruction fields; slave is the alu_ctrl_seq stage.
interface alu_ctrl_seq_if #(
  parameter int OP_W = 5
);
  logic            flush;
  logic            stall_in;
  logic            valid_in;
  logic            rtype;
  logic [1:0]      ALUOp;
  logic [2:0]      Funct3;
  logic [6:0]      Funct7;
  logic            jals;
  logic [OP_W-1:0] op_q;
  logic            valid_q;
  logic            md_start;
  logic [2:0]      md_funct;
  logic            md_last;
  logic            md_abort;
  logic            stall_req;

  modport master (
    output flush, stall_in, valid_in, rtype, ALUOp, Funct3, Funct7, jals,
    input  op_q, valid_q, md_start, md_funct, md_last, md_abort, stall_req
  );

  modport slave (
    input  flush, stall_in, valid_in, rtype, ALUOp, Funct3, Funct7, jals,
    output op_q, valid_q, md_start, md_funct, md_last, md_abort, stall_req
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder (ID/EX) with RV32M decode and a fixed-latency
// MUL/DIV sequencer that holds the pipeline while the iterative unit is busy.
module alu_ctrl_seq #(
  parameter int OP_W   = 5,
  parameter int EN_M   = 1,
  parameter int MD_LAT = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_ctrl_seq_if.slave bus
);
  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_r, op_d, dec_op;
  logic            valid_r, valid_d;
  logic            start_r, start_d;
  logic            abort_r, abort_d;
  logic [2:0]      funct_r, funct_d;
  logic            is_m, busy, last, advance, accept;

  // The counter counts down the remaining busy cycles; zero marks the final one.
  assign busy    = (state_q == RUN) && (cnt_q != '0);
  assign last    = (state_q == RUN) && (cnt_q == '0);
  assign advance = !bus.stall_in && !busy;
  assign is_m    = (EN_M != 0) && bus.rtype && (bus.ALUOp == 2'b10) &&
                   (bus.Funct7 == 7'b0000001);
  assign accept  = advance && bus.valid_in && !bus.flush && is_m;

  always_comb begin
    dec_op = '0;
    case (bus.ALUOp)
      2'b00: dec_op = OP_W'(4'b1011);
      2'b11: dec_op = bus.jals ? OP_W'(4'b1110) : OP_W'(4'b0010);
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_op = OP_W'(4'b1000);
          3'b001:  dec_op = OP_W'(4'b1001);
          3'b100:  dec_op = OP_W'(4'b0110);
          3'b101:  dec_op = OP_W'(4'b0111);
          default: dec_op = '0;
        endcase
      end
      2'b10: begin
        if (is_m) begin
          dec_op = OP_W'({2'b10, bus.Funct3});
        end else begin
          case (bus.Funct3)
            3'b000:  dec_op = (bus.Funct7 == 7'b0100000) ? OP_W'(4'b1010) : OP_W'(4'b1011);
            3'b001:  dec_op = OP_W'(4'b0100);
            3'b010:  dec_op = OP_W'(4'b1100);
            3'b100:  dec_op = (bus.Funct7 == 7'b0) ? OP_W'(4'b0011) : '0;
            3'b110:  dec_op = (bus.Funct7 == 7'b0) ? OP_W'(4'b0001) : '0;
            3'b111:  dec_op = OP_W'(4'b0000);
            3'b101:  dec_op = bus.Funct7[5] ? OP_W'(4'b1101) : OP_W'(4'b0101);
            default: dec_op = '0;
          endcase
        end
      end
      default: dec_op = '0;
    endcase
  end

  // A flush on the final busy cycle lets the op complete, so abort only fires while still busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_r;
    valid_d = valid_r;
    funct_d = funct_r;
    start_d = 1'b0;
    abort_d = 1'b0;

    if (advance) begin
      op_d    = dec_op;
      valid_d = bus.valid_in;
    end
    if (bus.flush) begin
      op_d    = '0;
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = CNT_INIT;
          funct_d = bus.Funct3;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush && !last) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (last) begin
          if (accept) begin
            cnt_d   = CNT_INIT;
            funct_d = bus.Funct3;
            start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_r    <= '0;
      valid_r <= 1'b0;
      funct_r <= 3'b000;
      start_r <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_r    <= op_d;
      valid_r <= valid_d;
      funct_r <= funct_d;
      start_r <= start_d;
      abort_r <= abort_d;
    end
  end

  assign bus.op_q      = op_r;
  assign bus.valid_q   = valid_r;
  assign bus.md_start  = start_r;
  assign bus.md_funct  = funct_r;
  assign bus.md_last   = last;
  assign bus.md_abort  = abort_r;
  assign bus.stall_req = busy;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: four instances (different EN_M/MD_LAT) share one stimulus
// stream and are each compared every cycle against a rule-table / elapsed-cycle reference.
module tb_alu_ctrl_seq;
  localparam int NI = 4;

  typedef struct packed {
    logic [1:0] aluOp;
    logic [2:0] funct3;
    logic [6:0] f7Val;
    logic [6:0] f7Mask;
    logic [3:0] code;
  } rule_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, stallIn, validIn, rtype, jals;
  logic [1:0] aluOp;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [4:0] opQ      [NI];
  logic       validQ   [NI];
  logic       mdStart  [NI];
  logic [2:0] mdFunct  [NI];
  logic       mdLast   [NI];
  logic       mdAbort  [NI];
  logic       stallReq [NI];

  bit         mRun     [NI];
  int         mElapsed [NI];
  logic [2:0] mFunct   [NI];
  logic [4:0] mOp      [NI];
  bit         mValid   [NI];
  bit         mStart   [NI];
  bit         mAbort   [NI];

  rule_t rules [13];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : inst
    alu_ctrl_seq_if #(.OP_W(5)) bus ();
    alu_ctrl_seq #(
      .OP_W(5),
      .EN_M((g == 3) ? 0 : 1),
      .MD_LAT((g == 0) ? 4 : ((g == 1) ? 1 : 32))
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    assign bus.flush    = flush;
    assign bus.stall_in = stallIn;
    assign bus.valid_in = validIn;
    assign bus.rtype    = rtype;
    assign bus.ALUOp    = aluOp;
    assign bus.Funct3   = funct3;
    assign bus.Funct7   = funct7;
    assign bus.jals     = jals;
    assign opQ[g]      = bus.op_q;
    assign validQ[g]   = bus.valid_q;
    assign mdStart[g]  = bus.md_start;
    assign mdFunct[g]  = bus.md_funct;
    assign mdLast[g]   = bus.md_last;
    assign mdAbort[g]  = bus.md_abort;
    assign stallReq[g] = bus.stall_req;
  end

  function automatic int latOf(input int g);
    if (g == 0) return 4;
    if (g == 1) return 1;
    return 32;
  endfunction

  function automatic bit enmOf(input int g);
    return g != 3;
  endfunction

  task automatic loadRules();
    rules[0]  = '{2'b01, 3'b000, 7'h00, 7'h00, 4'b1000};
    rules[1]  = '{2'b01, 3'b001, 7'h00, 7'h00, 4'b1001};
    rules[2]  = '{2'b01, 3'b100, 7'h00, 7'h00, 4'b0110};
    rules[3]  = '{2'b01, 3'b101, 7'h00, 7'h00, 4'b0111};
    rules[4]  = '{2'b10, 3'b000, 7'h20, 7'h7f, 4'b1010};
    rules[5]  = '{2'b10, 3'b000, 7'h00, 7'h00, 4'b1011};
    rules[6]  = '{2'b10, 3'b001, 7'h00, 7'h00, 4'b0100};
    rules[7]  = '{2'b10, 3'b010, 7'h00, 7'h00, 4'b1100};
    rules[8]  = '{2'b10, 3'b100, 7'h00, 7'h7f, 4'b0011};
    rules[9]  = '{2'b10, 3'b110, 7'h00, 7'h7f, 4'b0001};
    rules[10] = '{2'b10, 3'b111, 7'h00, 7'h00, 4'b0000};
    rules[11] = '{2'b10, 3'b101, 7'h20, 7'h20, 4'b1101};
    rules[12] = '{2'b10, 3'b101, 7'h00, 7'h20, 4'b0101};
  endtask

  function automatic logic [4:0] refDecode(input bit enm);
    if (enm && aluOp == 2'b10 && rtype && funct7 == 7'h01) return {2'b10, funct3};
    if (aluOp == 2'b00) return 5'b01011;
    if (aluOp == 2'b11) return jals ? 5'b01110 : 5'b00010;
    for (int r = 0; r < 13; r++) begin
      if (rules[r].aluOp == aluOp && rules[r].funct3 == funct3 &&
          (funct7 & rules[r].f7Mask) == rules[r].f7Val)
        return {1'b0, rules[r].code};
    end
    return 5'b00000;
  endfunction

  function automatic bit expBusy(input int g);
    return mRun[g] && (mElapsed[g] < latOf(g) - 1);
  endfunction

  function automatic bit expLast(input int g);
    return mRun[g] && (mElapsed[g] == latOf(g) - 1);
  endfunction

  task automatic modelReset();
    for (int g = 0; g < NI; g++) begin
      mRun[g] = 0; mElapsed[g] = 0; mFunct[g] = 3'b000;
      mOp[g] = 5'b00000; mValid[g] = 0; mStart[g] = 0; mAbort[g] = 0;
    end
  endtask

  task automatic modelStep();
    for (int g = 0; g < NI; g++) begin
      bit busyNow, lastNow, adv, isM, take;
      busyNow = expBusy(g);
      lastNow = expLast(g);
      adv  = !stallIn && !busyNow;
      isM  = enmOf(g) && aluOp == 2'b10 && rtype && funct7 == 7'h01;
      take = adv && validIn && !flush && isM;
      mAbort[g] = mRun[g] && flush && !lastNow;
      mStart[g] = take;
      if (adv) begin
        mOp[g] = refDecode(enmOf(g));
        mValid[g] = validIn;
      end
      if (flush) begin
        mOp[g] = 5'b00000;
        mValid[g] = 0;
      end
      if (take) begin
        mRun[g] = 1; mElapsed[g] = 0; mFunct[g] = funct3;
      end else if (mRun[g]) begin
        if (lastNow || flush) mRun[g] = 0;
        else mElapsed[g]++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("op_q%0d", g), 32'(opQ[g]), 32'(mOp[g]));
      checkOutput($sformatf("valid_q%0d", g), 32'(validQ[g]), 32'(mValid[g]));
      checkOutput($sformatf("md_start%0d", g), 32'(mdStart[g]), 32'(mStart[g]));
      checkOutput($sformatf("md_funct%0d", g), 32'(mdFunct[g]), 32'(mFunct[g]));
      checkOutput($sformatf("md_last%0d", g), 32'(mdLast[g]), 32'(expLast(g)));
      checkOutput($sformatf("md_abort%0d", g), 32'(mdAbort[g]), 32'(mAbort[g]));
      checkOutput($sformatf("stall_req%0d", g), 32'(stallReq[g]), 32'(expBusy(g)));
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("%s_op%0d", tag, g), 32'(opQ[g]), 32'd0);
      checkOutput($sformatf("%s_valid%0d", tag, g), 32'(validQ[g]), 32'd0);
      checkOutput($sformatf("%s_start%0d", tag, g), 32'(mdStart[g]), 32'd0);
      checkOutput($sformatf("%s_funct%0d", tag, g), 32'(mdFunct[g]), 32'd0);
      checkOutput($sformatf("%s_last%0d", tag, g), 32'(mdLast[g]), 32'd0);
      checkOutput($sformatf("%s_abort%0d", tag, g), 32'(mdAbort[g]), 32'd0);
      checkOutput($sformatf("%s_stall%0d", tag, g), 32'(stallReq[g]), 32'd0);
    end
  endtask

  // Inputs change just after a falling edge; outputs are compared on the next falling edge.
  task automatic applyStimulus(input bit v, input logic [1:0] al, input logic [2:0] f3,
                               input logic [6:0] f7, input bit rt, input bit js,
                               input bit fl, input bit st);
    validIn = v; aluOp = al; funct3 = f3; funct7 = f7;
    rtype = rt; jals = js; flush = fl; stallIn = st;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic drain();
    repeat (40) applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
  endtask

  initial begin
    logic [6:0] f7;
    rst_n = 1'b0;
    flush = 0; stallIn = 0; validIn = 0; rtype = 0; jals = 0;
    aluOp = 2'b00; funct3 = 3'b000; funct7 = 7'h00;
    loadRules();
    modelReset();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 2'b10, 3'b000, 7'h20, 1, 0, 0, 0);
    checkOutput("sub_op", 32'(opQ[0]), 32'h0a);
    checkOutput("sub_valid", 32'(validQ[0]), 32'd1);
    applyStimulus(1, 2'b10, 3'b101, 7'h20, 1, 0, 0, 0);
    checkOutput("sra_op", 32'(opQ[0]), 32'h0d);
    applyStimulus(1, 2'b01, 3'b001, 7'h00, 0, 0, 0, 0);
    checkOutput("bne_op", 32'(opQ[0]), 32'h09);
    applyStimulus(1, 2'b11, 3'b000, 7'h00, 0, 1, 0, 0);
    checkOutput("jal_op", 32'(opQ[0]), 32'h0e);

    applyStimulus(1, 2'b10, 3'b001, 7'h01, 1, 0, 0, 0);
    checkOutput("mulh_op", 32'(opQ[0]), 32'h11);
    checkOutput("mulh_start", 32'(mdStart[0]), 32'd1);
    checkOutput("mulh_funct", 32'(mdFunct[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
      checkOutput("mulh_hold_op", 32'(opQ[0]), 32'h11);
      checkOutput("mulh_stall", 32'(stallReq[0]), (i < 2) ? 32'd1 : 32'd0);
      checkOutput("mulh_last", 32'(mdLast[0]), (i < 2) ? 32'd0 : 32'd1);
    end
    applyStimulus(1, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
    checkOutput("add_after_mul", 32'(opQ[0]), 32'h0b);
    drain();

    applyStimulus(1, 2'b10, 3'b000, 7'h01, 1, 0, 0, 0);
    checkOutput("nom_op", 32'(opQ[3]), 32'h0b);
    checkOutput("nom_start", 32'(mdStart[3]), 32'd0);
    checkOutput("nom_stall", 32'(stallReq[3]), 32'd0);
    drain();
    applyStimulus(1, 2'b10, 3'b000, 7'h01, 0, 0, 0, 0);
    checkOutput("nortype_op", 32'(opQ[0]), 32'h0b);
    checkOutput("nortype_start", 32'(mdStart[0]), 32'd0);
    drain();

    applyStimulus(1, 2'b10, 3'b100, 7'h01, 1, 0, 0, 0);
    repeat (9) applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 1);
    checkOutput("div_busy10_stall", 32'(stallReq[2]), 32'd1);
    applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 1, 1);
    checkOutput("flush_abort", 32'(mdAbort[2]), 32'd1);
    checkOutput("flush_stall", 32'(stallReq[2]), 32'd0);
    checkOutput("flush_valid", 32'(validQ[2]), 32'd0);
    checkOutput("flush_last", 32'(mdLast[2]), 32'd0);
    applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
    checkOutput("abort_pulse_end", 32'(mdAbort[2]), 32'd0);
    drain();

    applyStimulus(1, 2'b10, 3'b100, 7'h01, 1, 0, 0, 0);
    repeat (31) applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 1);
    checkOutput("div_stall_last", 32'(mdLast[2]), 32'd1);
    applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
    checkOutput("div_done_last", 32'(mdLast[2]), 32'd0);
    drain();

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 2'b10, 3'b110, 7'h01, 1, 0, 0, 0);
      checkOutput("rem_op", 32'(opQ[1]), 32'h16);
      checkOutput("rem_start", 32'(mdStart[1]), 32'd1);
      checkOutput("rem_last", 32'(mdLast[1]), 32'd1);
      checkOutput("rem_stall", 32'(stallReq[1]), 32'd0);
    end
    drain();

    applyStimulus(1, 2'b10, 3'b100, 7'h01, 1, 0, 0, 0);
    repeat (14) applyStimulus(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
    checkOutput("pre_reset_stall", 32'(stallReq[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midrun_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 2'b00, 3'b000, 7'h00, 0, 0, 0, 0);
    checkOutput("post_reset_add", 32'(opQ[2]), 32'h0b);
    checkOutput("post_reset_valid", 32'(validQ[2]), 32'd1);

    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), f7, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
